// File: rtl/padding_stripper.sv
// Strips SHAKE pad10*1 (0x1F ... 0x80 / merged 0x9F) from a stream of rate blocks and
// recovers the message word stream with an exact byte count on the final beat.
//
// state      | meaning
// STREAM     | pass words through; in the last block watch for a 0x1F candidate
// HOLD       | candidate held, counting trailing zero words
// FLUSH_HELD | candidate proved to be data: emit it
// FLUSH_ZERO | emit the zero words counted while holding
// TRIG       | reprocess the word that ended the hold
// DONE       | final beat emitted; idle until clear
// ERROR      | malformed padding; idle until clear
module padding_stripper #(
  parameter int RATE_WORDS = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        in_last_block,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [3:0]  out_valid_bytes,
  output logic        out_last,
  output logic        done,
  output logic        pad_error
);
  localparam int W     = 64;
  localparam int NB    = 8;
  localparam int BW    = 4;
  localparam int IDX_W = $clog2(RATE_WORDS);

  typedef enum logic [2:0] {
    ST_STREAM, ST_HOLD, ST_FLUSH_HELD, ST_FLUSH_ZERO, ST_TRIG, ST_DONE, ST_ERROR
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] word_idx_q, zero_cnt_q, idx_next;
  logic             last_blk_q, trig_final_q;
  logic [W-1:0]     held_q, trig_q, out_data_q;
  logic [2:0]       held_k_q;
  logic             out_valid_q, out_last_q, done_q, pad_error_q;
  logic [BW-1:0]    out_vb_q;

  logic             can_load, in_fire, last_blk_eff, in_final;
  logic [W-1:0]     proc_word, fin_data, held_data;
  logic [2:0]       lnz_all, lnz_hi;
  logic             nz_all, nz_hi, is_cand, fin_9f, fin_80, fin_msg_ok, fin_empty;
  logic [BW-1:0]    fin_vb, held_vb;

  function automatic logic [W-1:0] byte_mask(input logic [BW-1:0] n);
    byte_mask = '0;
    for (int i = 0; i < NB; i++)
      if (i + int'(n) >= NB) byte_mask[8*i +: 8] = 8'hFF;
  endfunction

  assign can_load     = !out_valid_q || out_ready;
  assign in_ready     = (state_q == ST_STREAM || state_q == ST_HOLD) && can_load;
  assign in_fire      = in_valid && in_ready;
  assign last_blk_eff = (word_idx_q == '0) ? in_last_block : last_blk_q;
  assign in_final     = last_blk_eff && (word_idx_q == IDX_W'(RATE_WORDS - 1));
  assign idx_next     = (word_idx_q == IDX_W'(RATE_WORDS - 1)) ? '0 : word_idx_q + 1'b1;
  assign proc_word    = (state_q == ST_TRIG) ? trig_q : in_data;

  // lnz_hi ignores byte 0 so a terminator word can be searched for its separator
  always_comb begin
    lnz_all = '0;
    lnz_hi  = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (proc_word[8*i +: 8] != 8'h00) lnz_all = 3'(i);
      if (i >= 1 && proc_word[8*i +: 8] != 8'h00) lnz_hi = 3'(i);
    end
    nz_all     = |proc_word;
    nz_hi      = |proc_word[W-1:8];
    is_cand    = nz_all && (proc_word[8*int'(lnz_all) +: 8] == 8'h1F);
    fin_9f     = proc_word[7:0] == 8'h9F;
    fin_80     = proc_word[7:0] == 8'h80;
    fin_msg_ok = fin_9f || (fin_80 && nz_hi && proc_word[8*int'(lnz_hi) +: 8] == 8'h1F);
    fin_empty  = fin_80 && !nz_hi;
    fin_vb     = fin_9f ? 4'd7 : 4'd7 - {1'b0, lnz_hi};
    fin_data   = proc_word & byte_mask(fin_vb);
    held_vb    = 4'd7 - {1'b0, held_k_q};
    held_data  = held_q & byte_mask(held_vb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      state_q      <= ST_STREAM;
      word_idx_q   <= '0;
      zero_cnt_q   <= '0;
      last_blk_q   <= 1'b0;
      trig_final_q <= 1'b0;
      held_q       <= '0;
      held_k_q     <= '0;
      trig_q       <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      out_vb_q     <= '0;
      done_q       <= 1'b0;
      pad_error_q  <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
        if (out_last_q) done_q <= 1'b1;
      end
      if (in_fire) begin
        word_idx_q <= idx_next;
        if (word_idx_q == '0) last_blk_q <= in_last_block;
      end
      case (state_q)
        ST_STREAM, ST_HOLD: if (in_fire) begin
          if (!last_blk_eff) begin
            out_valid_q <= 1'b1; out_data_q <= in_data; out_vb_q <= 4'd8; out_last_q <= 1'b0;
          end else if (in_final) begin
            if (fin_msg_ok && state_q == ST_HOLD) begin
              trig_q <= in_data; trig_final_q <= 1'b1; state_q <= ST_FLUSH_HELD;
            end else if (fin_msg_ok) begin
              out_valid_q <= 1'b1; out_data_q <= fin_data; out_vb_q <= fin_vb; out_last_q <= 1'b1;
              state_q <= ST_DONE;
            end else if (fin_empty && state_q == ST_HOLD) begin
              out_valid_q <= 1'b1; out_data_q <= held_data; out_vb_q <= held_vb; out_last_q <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              pad_error_q <= 1'b1; state_q <= ST_ERROR;
            end
          end else if (state_q == ST_STREAM) begin
            if (is_cand) begin
              held_q <= in_data; held_k_q <= lnz_all; zero_cnt_q <= '0; state_q <= ST_HOLD;
            end else begin
              out_valid_q <= 1'b1; out_data_q <= in_data; out_vb_q <= 4'd8; out_last_q <= 1'b0;
            end
          end else if (!nz_all) begin
            zero_cnt_q <= zero_cnt_q + 1'b1;
          end else begin
            trig_q <= in_data; trig_final_q <= 1'b0; state_q <= ST_FLUSH_HELD;
          end
        end
        ST_FLUSH_HELD: if (can_load) begin
          out_valid_q <= 1'b1; out_data_q <= held_q; out_vb_q <= 4'd8; out_last_q <= 1'b0;
          state_q <= ST_FLUSH_ZERO;
        end
        ST_FLUSH_ZERO: begin
          if (zero_cnt_q == '0) begin
            state_q <= ST_TRIG;
          end else if (can_load) begin
            out_valid_q <= 1'b1; out_data_q <= '0; out_vb_q <= 4'd8; out_last_q <= 1'b0;
            zero_cnt_q <= zero_cnt_q - 1'b1;
          end
        end
        ST_TRIG: if (can_load) begin
          if (trig_final_q && fin_msg_ok) begin
            out_valid_q <= 1'b1; out_data_q <= fin_data; out_vb_q <= fin_vb; out_last_q <= 1'b1;
            state_q <= ST_DONE;
          end else if (trig_final_q) begin
            pad_error_q <= 1'b1; state_q <= ST_ERROR;
          end else if (is_cand) begin
            held_q <= trig_q; held_k_q <= lnz_all; zero_cnt_q <= '0; state_q <= ST_HOLD;
          end else begin
            out_valid_q <= 1'b1; out_data_q <= trig_q; out_vb_q <= 4'd8; out_last_q <= 1'b0;
            state_q <= ST_STREAM;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;
  assign out_valid_bytes = out_vb_q;
  assign out_last        = out_last_q;
  assign done            = done_q;
  assign pad_error       = pad_error_q;
endmodule
